// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// The master drives the count controls; the slave (the counter) returns value and flags.
interface updown_counter_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cout;
    logic             carry;
    logic             borrow;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up, load, load_val,
        input  cout, carry, borrow, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_val,
        output cout, carry, borrow, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter, modulus MAX_VAL+1, with load, enable,
// wrap or saturate boundaries, and registered carry/borrow pulses for cascading.
module updown_counter_param #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX     = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];

    logic [WIDTH-1:0] cnt;
    logic             carry_q;
    logic             borrow_q;
    logic [WIDTH:0]   inc_ext;
    logic             top_hit;
    logic             bottom_hit;
    logic             load_over;

    // One extra bit so MAX_VAL = 2**WIDTH-1 is detected before the adder wraps.
    always_comb begin
        inc_ext    = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
        top_hit    = (inc_ext > MAX_EXT);
        bottom_hit = (cnt == '0);
        load_over  = ({1'b0, bus.load_val} > MAX_EXT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            if (bus.load) begin
                cnt <= load_over ? MAX : bus.load_val;
            end else if (bus.en) begin
                if (bus.up) begin
                    if (!top_hit) begin
                        cnt <= inc_ext[WIDTH-1:0];
                    end else if (!SATURATE) begin
                        cnt     <= '0;
                        carry_q <= 1'b1;
                    end
                end else begin
                    if (!bottom_hit) begin
                        cnt <= cnt - {{(WIDTH-1){1'b0}}, 1'b1};
                    end else if (!SATURATE) begin
                        cnt      <= MAX;
                        borrow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cout   = cnt;
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
    assign bus.at_max = (cnt == MAX);
    assign bus.at_min = (cnt == '0);
endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four configurations driven in lockstep,
// directed boundary sequences followed by random stimulus against an arithmetic model.
module tb_updown_counter_param;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Model configuration: decade wrap, decade saturate, full 8-bit wrap, modulus 2.
    int unsigned maxv [NDUT] = '{9, 9, 255, 1};
    bit          satm [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int unsigned mask [NDUT] = '{15, 15, 255, 3};

    int unsigned m_cnt [NDUT];
    bit          m_car [NDUT];
    bit          m_bor [NDUT];

    logic [31:0] oc  [NDUT];
    logic [3:0]  ofl [NDUT];

    updown_counter_param_if #(.WIDTH(4)) b0 ();
    updown_counter_param_if #(.WIDTH(4)) b1 ();
    updown_counter_param_if #(.WIDTH(8)) b2 ();
    updown_counter_param_if #(.WIDTH(2)) b3 ();

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    updown_counter_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));
    updown_counter_param #(.WIDTH(2), .MAX_VAL(1),   .SATURATE(1'b0)) u3 (.clk(clk), .reset(reset), .bus(b3));

    assign b0.en = en; assign b0.up = up; assign b0.load = load; assign b0.load_val = lv[3:0];
    assign b1.en = en; assign b1.up = up; assign b1.load = load; assign b1.load_val = lv[3:0];
    assign b2.en = en; assign b2.up = up; assign b2.load = load; assign b2.load_val = lv;
    assign b3.en = en; assign b3.up = up; assign b3.load = load; assign b3.load_val = lv[1:0];

    assign oc[0] = 32'(b0.cout); assign ofl[0] = {b0.carry, b0.borrow, b0.at_max, b0.at_min};
    assign oc[1] = 32'(b1.cout); assign ofl[1] = {b1.carry, b1.borrow, b1.at_max, b1.at_min};
    assign oc[2] = 32'(b2.cout); assign ofl[2] = {b2.carry, b2.borrow, b2.at_max, b2.at_min};
    assign oc[3] = 32'(b3.cout); assign ofl[3] = {b3.carry, b3.borrow, b3.at_max, b3.at_min};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Counting modulo maxv+1 with plain integer arithmetic.
    task automatic model_update();
        int unsigned v;
        for (int i = 0; i < NDUT; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_car[i] = 0; m_bor[i] = 0;
            end else if (load) begin
                v = int'(lv) & mask[i];
                m_cnt[i] = (v > maxv[i]) ? maxv[i] : v;
                m_car[i] = 0; m_bor[i] = 0;
            end else if (en) begin
                m_car[i] = 0; m_bor[i] = 0;
                if (up) begin
                    if (satm[i]) m_cnt[i] = (m_cnt[i] + 1 > maxv[i]) ? maxv[i] : m_cnt[i] + 1;
                    else begin
                        m_car[i] = (m_cnt[i] + 1 > maxv[i]);
                        m_cnt[i] = (m_cnt[i] + 1) % (maxv[i] + 1);
                    end
                end else begin
                    if (satm[i]) m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    else begin
                        m_bor[i] = (m_cnt[i] == 0);
                        m_cnt[i] = (m_cnt[i] + maxv[i]) % (maxv[i] + 1);
                    end
                end
            end else begin
                m_car[i] = 0; m_bor[i] = 0;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("d%0d_cout", i),   oc[i],     m_cnt[i]);
            check_eq($sformatf("d%0d_carry", i),  ofl[i][3], 32'(m_car[i]));
            check_eq($sformatf("d%0d_borrow", i), ofl[i][2], 32'(m_bor[i]));
            check_eq($sformatf("d%0d_at_max", i), ofl[i][1], 32'(m_cnt[i] == maxv[i]));
            check_eq($sformatf("d%0d_at_min", i), ofl[i][0], 32'(m_cnt[i] == 0));
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [7:0] v);
        reset = r; en = e; up = u; load = l; lv = v;
    endtask

    int unsigned dec_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int unsigned dn_seq [3]  = '{1, 0, 9};
    int unsigned fw_seq [3]  = '{255, 0, 1};

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd7);

        // Reset wins over load and count.
        step();
        check_eq("rst_cout", oc[0], 0);
        check_eq("rst_at_min", ofl[0][0], 1);
        step();

        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            check_eq("dec_up_cout", oc[0], dec_up[k]);
            check_eq("dec_up_carry", ofl[0][3], 32'(dec_up[k] == 0));
            check_eq("dec_up_at_max", ofl[0][1], 32'(dec_up[k] == 9));
        end

        up = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("dn_cout", oc[0], dn_seq[k]);
            check_eq("dn_borrow", ofl[0][2], 32'(dn_seq[k] == 9));
        end
        up = 1'b1;
        step();
        check_eq("dir_cout", oc[0], 0);
        check_eq("dir_carry", ofl[0][3], 1);

        // Saturating instance: hold at both boundaries, no pulses.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd8);
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("sat_up_cout", oc[1], 9);
            check_eq("sat_up_carry", ofl[1][3], 0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("sat_dn_cout", oc[1], 0);
            check_eq("sat_dn_borrow", ofl[1][2], 0);
        end

        // Load priority over enable, and clamp above MAX_VAL.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        step();
        check_eq("load_cout", oc[0], 5);
        lv = 8'd14;
        step();
        check_eq("clamp_cout", oc[0], 9);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("hold_cout", oc[0], 9);
        end

        // Full-width wrap on the 8-bit instance, then reset landing on a wrap edge.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd254);
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("fw_cout", oc[2], fw_seq[k]);
            check_eq("fw_carry", ofl[2][3], 32'(fw_seq[k] == 0));
        end
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check_eq("fw_pre_cout", oc[2], 255);
        reset = 1'b1;
        step();
        check_eq("fw_rst_cout", oc[2], 0);
        check_eq("fw_rst_carry", ofl[2][3], 0);
        reset = 1'b0;

        // Modulus-2 instance toggles with a pulse every second step.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) step();

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  ($urandom_range(7) == 0), 8'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised bidirectional counter: next generation of the team's 4-bit up/down counter.
- Adds configurable width, programmable modulus, count enable, parallel load, and wrap or saturate mode.
- Adds registered carry/borrow pulses and boundary flags for cascading into multi-digit counters, position encoders and reversible timers.
- Single clock domain; reset is synchronous.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MAX_VAL, 2**WIDTH-1, highest count value; counting spans 0..MAX_VAL (modulus MAX_VAL+1). Legal range 1..2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous reset, active-high
- en  input  1  count enable; counter holds when low
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value captured when load=1
- cout  output  WIDTH  registered counter value
- carry  output  1  one-cycle pulse: up-wrap from MAX_VAL to 0 occurred (wrap mode only)
- borrow  output  1  one-cycle pulse: down-wrap from 0 to MAX_VAL occurred (wrap mode only)
- at_max  output  1  combinational: cout == MAX_VAL
- at_min  output  1  combinational: cout == 0

Behaviour:
- Clocking and reset: one clock (clk). Reset (reset) is synchronous and active-high.
- Reset values: cout=0, carry=0, borrow=0, hence at_min=1 and at_max=0.
- Priority each rising edge: reset > load > en > hold.
- Load:
  - cout <= load_val when load_val <= MAX_VAL; otherwise cout <= MAX_VAL (clamp).
  - carry and borrow are 0 in a load cycle. load ignores en and up.
- Count (en=1, load=0):
  - up=1, cout<MAX_VAL: cout <= cout+1.
  - up=0, cout>0: cout <= cout-1.
  - up=1, cout==MAX_VAL: SATURATE=0 gives cout <= 0 and carry <= 1. SATURATE=1 gives cout holds and carry stays 0.
  - up=0, cout==0: SATURATE=0 gives cout <= MAX_VAL and borrow <= 1. SATURATE=1 gives cout holds and borrow stays 0.
- Hold (en=0, load=0): cout holds; carry=0, borrow=0.
- Latency:
  - cout, carry and borrow are registered and change one cycle after the controlling edge.
  - carry/borrow are high for exactly the single cycle in which cout shows the wrapped value.
  - Both deassert on the next edge unless another wrap occurs (only possible with MAX_VAL=1 or when wrapping every cycle).
- Arithmetic: modulo MAX_VAL+1, not 2**WIDTH. Increment/decrement use WIDTH+1-bit internal compare so that MAX_VAL=2**WIDTH-1 wraps correctly with no overflow.
- Direction change: up may toggle on any cycle. The next step uses the new direction with no dead cycle.
- carry and borrow are never asserted simultaneously.
- MAX_VAL=1 edge case: the counter toggles 0/1 every enabled cycle. In wrap mode a carry (up) or borrow (down) fires on every second step.
- Reset mid-count (including in a wrap cycle): cout=0 and flags=0 on the next edge. Reset overrides load.
- No X propagation: all registers are initialised by reset only, and the bench applies reset before checking.

Test Plan:
- Reset: WIDTH=4, MAX_VAL=9. Assert reset 2 cycles with en=1, up=1, load=1 -> cout=0, carry=0, borrow=0, at_min=1 after the first edge.
- Decade up-wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, en=1, up=1 for 12 cycles -> cout 1..9,0,1,2. carry=1 only in the cycle cout=0, at_max=1 while cout=9.
- Down-wrap and direction change: from cout=2, up=0 for 3 cycles -> cout 1,0,9 with borrow=1 at cout=9. Then up=1 -> cout=0 with carry=1.
- Saturate: SATURATE=1, MAX_VAL=9. Load 8, up=1 for 4 cycles -> 9,9,9,9 with carry never high. Then up=0 from 1 for 3 cycles -> 0,0,0 with borrow never high.
- Load priority and clamp: load=1, en=1, load_val=5 -> cout=5. load_val=14 -> cout=9 (clamped). en=0 for 3 cycles -> cout stays 9.
- Full-width wrap: WIDTH=8, MAX_VAL=255. Load 254, up=1 for 3 cycles -> 255,0,1 with carry at 0. Reset asserted in the wrap cycle -> cout=0, carry=0.
